gato_controller: RTL and testbench

- Sequencing controller for the tic-tac-toe (gato) game: owns the cursor, the 3x3 board state, turn alternation, per-turn timeout and end-of-game detection.
- Sits between the debounced push-buttons (mover, colocar) and the display/LED logic.
- Replaces the loose coupling of separate move/turn/matrix/timer blocks with one FSM that guarantees a single legal placement per turn and a registered, glitch-free win/draw result.

---
 rtl/gato_pkg.sv | 36 +++
 rtl/gato_win_detect.sv | 23 ++
 rtl/gato_controller.sv | 153 +++++++++++++++
 tb/tb_gato_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gato_pkg.sv
// Shared types and the winning-line table for the tic-tac-toe (gato) controller.
package gato_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      MARK_X = 2'b01,
      MARK_O = 2'b10
   } cell_t;

   typedef cell_t [8:0] board_t;

   typedef enum logic [1:0] {
      PLAY  = 2'b00,
      CHECK = 2'b01,
      WIN   = 2'b10,
      DRAW  = 2'b11
   } gato_state_t;

   localparam int unsigned N_CELLS = 9;
   localparam int unsigned N_LINES = 8;

   localparam board_t BOARD_EMPTY = '{default: EMPTY};

   // Rows, columns, then both diagonals (row-major cell indices).
   localparam logic [3:0] WIN_LINES [N_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

endpackage

// File: rtl/gato_win_detect.sv
// Combinational three-in-a-row detector over the registered board.
module gato_win_detect
   import gato_pkg::*;
(
   input  board_t board,
   output logic   line_win,
   output cell_t  win_mark
);

   always_comb begin
      line_win = 1'b0;
      win_mark = EMPTY;
      for (int l = 0; l < int'(N_LINES); l++) begin
         if ((board[WIN_LINES[l][0]] != EMPTY) &&
             (board[WIN_LINES[l][0]] == board[WIN_LINES[l][1]]) &&
             (board[WIN_LINES[l][1]] == board[WIN_LINES[l][2]])) begin
            line_win = 1'b1;
            win_mark = board[WIN_LINES[l][0]];
         end
      end
   end

endmodule

// File: rtl/gato_controller.sv
// Tic-tac-toe sequencing controller: cursor, board, turn alternation, turn timer
// and registered win/draw result.
module gato_controller
   import gato_pkg::*;
#(
   parameter int unsigned TURN_CYCLES = 50_000_000,
   parameter int unsigned TW          = $clog2(TURN_CYCLES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mover,
   input  logic          colocar,
   output logic [3:0]    pos,
   output logic [17:0]   board,
   output logic          jugador,
   output logic [TW-1:0] time_left,
   output logic          timeout,
   output logic          illegal,
   output logic          win,
   output logic [1:0]    winner,
   output logic          draw
);

   localparam logic [TW-1:0] TIME_RELOAD = TW'(TURN_CYCLES - 1);
   localparam logic [3:0]    LAST_CELL   = 4'(N_CELLS - 1);
   localparam logic [3:0]    ALL_MOVES   = 4'(N_CELLS);

   gato_state_t   state_q, state_d;
   logic [3:0]    pos_q, pos_d;
   board_t        board_q, board_d;
   logic          jugador_q, jugador_d;
   logic [3:0]    moves_q, moves_d;
   logic [TW-1:0] time_q, time_d;
   logic          timeout_q, timeout_d;
   logic          illegal_q, illegal_d;
   logic          win_q, win_d;
   cell_t         winner_q, winner_d;
   logic          draw_q, draw_d;

   logic          line_win_c;
   cell_t         win_mark_c;

   gato_win_detect u_win_detect (
      .board    (board_q),
      .line_win (line_win_c),
      .win_mark (win_mark_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= PLAY;
         pos_q     <= '0;
         board_q   <= BOARD_EMPTY;
         jugador_q <= 1'b1;
         moves_q   <= '0;
         time_q    <= TIME_RELOAD;
         timeout_q <= 1'b0;
         illegal_q <= 1'b0;
         win_q     <= 1'b0;
         winner_q  <= EMPTY;
         draw_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         board_q   <= board_d;
         jugador_q <= jugador_d;
         moves_q   <= moves_d;
         time_q    <= time_d;
         timeout_q <= timeout_d;
         illegal_q <= illegal_d;
         win_q     <= win_d;
         winner_q  <= winner_d;
         draw_q    <= draw_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      board_d   = board_q;
      jugador_d = jugador_q;
      moves_d   = moves_q;
      time_d    = time_q;
      timeout_d = 1'b0;
      illegal_d = 1'b0;
      win_d     = win_q;
      winner_d  = winner_q;
      draw_d    = draw_q;

      unique case (state_q)
         PLAY: begin
            // A valid placement takes priority over both mover and timer expiry.
            if (colocar && (board_q[pos_q] == EMPTY)) begin
               board_d[pos_q] = jugador_q ? MARK_X : MARK_O;
               moves_d        = moves_q + 4'd1;
               state_d        = CHECK;
            end else begin
               if (colocar) begin
                  illegal_d = 1'b1;
               end else if (mover) begin
                  pos_d = (pos_q == LAST_CELL) ? 4'd0 : pos_q + 4'd1;
               end
               if (time_q == '0) begin
                  timeout_d = 1'b1;
                  jugador_d = ~jugador_q;
                  time_d    = TIME_RELOAD;
               end else begin
                  time_d = time_q - TW'(1);
               end
            end
         end
         CHECK: begin
            if (line_win_c) begin
               state_d  = WIN;
               win_d    = 1'b1;
               winner_d = win_mark_c;
            end else if (moves_q == ALL_MOVES) begin
               state_d = DRAW;
               draw_d  = 1'b1;
            end else begin
               state_d   = PLAY;
               jugador_d = ~jugador_q;
               time_d    = TIME_RELOAD;
            end
         end
         WIN, DRAW: begin
            // Restart keeps the cursor where the players left it.
            if (colocar) begin
               state_d   = PLAY;
               board_d   = BOARD_EMPTY;
               jugador_d = 1'b1;
               moves_d   = '0;
               time_d    = TIME_RELOAD;
               win_d     = 1'b0;
               winner_d  = EMPTY;
               draw_d    = 1'b0;
            end
         end
         default: state_d = PLAY;
      endcase
   end

   assign pos       = pos_q;
   assign board     = board_q;
   assign jugador   = jugador_q;
   assign time_left = time_q;
   assign timeout   = timeout_q;
   assign illegal   = illegal_q;
   assign win       = win_q;
   assign winner    = winner_q;
   assign draw      = draw_q;

endmodule

// File: tb/tb_gato_controller.sv
// Directed self-checking bench for gato_controller with a 16-cycle turn.
module tb_gato_controller;

   localparam int unsigned TC = 16;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mover;
   logic          colocar;
   logic [3:0]    pos;
   logic [17:0]   board;
   logic          jugador;
   logic [TW-1:0] time_left;
   logic          timeout;
   logic          illegal;
   logic          win;
   logic [1:0]    winner;
   logic          draw;

   int            n_assert = 0;
   int            n_fail   = 0;
   int            cur_pos;
   logic [17:0]   exp_board;
   logic          exp_jug;

   gato_controller #(.TURN_CYCLES(TC)) dut (
      .clk       (clk),
      .rst       (rst),
      .mover     (mover),
      .colocar   (colocar),
      .pos       (pos),
      .board     (board),
      .jugador   (jugador),
      .time_left (time_left),
      .timeout   (timeout),
      .illegal   (illegal),
      .win       (win),
      .winner    (winner),
      .draw      (draw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst       = 1'b1;
      cur_pos   = 0;
      exp_board = '0;
      exp_jug   = 1'b1;
   endtask

   task automatic pulse_mover();
      mover = 1'b1;
      step();
      mover   = 1'b0;
      cur_pos = (cur_pos == 8) ? 0 : cur_pos + 1;
   endtask

   task automatic pulse_colocar();
      colocar = 1'b1;
      step();
      colocar = 1'b0;
   endtask

   task automatic move_to(input int t);
      while (cur_pos != t) pulse_mover();
   endtask

   task automatic mark_expected(input int t);
      logic [1:0] code;
      code      = exp_jug ? 2'b01 : 2'b10;
      exp_board = exp_board | (18'(code) << (2 * t));
   endtask

   // Move, place for the current player, then let the one-cycle check finish.
   task automatic place_at(input int t);
      move_to(t);
      mark_expected(t);
      pulse_colocar();
      step();
      exp_jug = ~exp_jug;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; mover = 1'b0; colocar = 1'b0;
      cur_pos = 0; exp_board = '0; exp_jug = 1'b1;
      step();
      step();
      chk("rst_pos",     32'(pos), 32'd0);
      chk("rst_board",   32'(board), 32'd0);
      chk("rst_jugador", 32'(jugador), 32'd1);
      chk("rst_time",    32'(time_left), 32'd15);
      chk("rst_flags",   32'({win, draw, timeout, illegal}), 32'd0);
      chk("rst_winner",  32'(winner), 32'd0);

      // Cursor walk with wrap-around
      do_reset();
      for (int i = 0; i < 9; i++) begin
         pulse_mover();
         chk("walk_pos", 32'(pos), 32'((i + 1) % 9));
      end
      chk("walk_board",   32'(board), 32'd0);
      chk("walk_jugador", 32'(jugador), 32'd1);
      chk("walk_time",    32'(time_left), 32'd6);

      // X wins along the top row
      do_reset();
      place_at(0);
      chk("g1_board0", 32'(board), 32'h1);
      chk("g1_jug0",   32'(jugador), 32'd0);
      place_at(3);
      chk("g1_board1", 32'(board), 32'h81);
      place_at(1);
      place_at(4);
      chk("g1_board3", 32'(board), 32'h285);
      move_to(2);
      mark_expected(2);
      pulse_colocar();
      chk("g1_board_final", 32'(board), 32'h295);
      chk("g1_win_lat1",    32'(win), 32'd0);
      step();
      chk("g1_win",    32'(win), 32'd1);
      chk("g1_winner", 32'(winner), 32'd1);
      chk("g1_draw",   32'(draw), 32'd0);
      mover = 1'b1;
      step();
      step();
      mover = 1'b0;
      chk("g1_frozen_pos",   32'(pos), 32'd2);
      chk("g1_frozen_board", 32'(board), 32'(exp_board));
      chk("g1_frozen_jug",   32'(jugador), 32'd1);
      pulse_colocar();
      chk("g1_restart_board", 32'(board), 32'd0);
      chk("g1_restart_jug",   32'(jugador), 32'd1);
      chk("g1_restart_pos",   32'(pos), 32'd2);
      chk("g1_restart_win",   32'({win, winner, draw}), 32'd0);
      chk("g1_restart_time",  32'(time_left), 32'd15);

      // Placement on an occupied cell
      do_reset();
      place_at(0);
      chk("ill_pre_time", 32'(time_left), 32'd15);
      pulse_colocar();
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_board", 32'(board), 32'h1);
      chk("ill_jug",   32'(jugador), 32'd0);
      chk("ill_time",  32'(time_left), 32'd14);
      step();
      chk("ill_clear", 32'(illegal), 32'd0);

      // Turn timeout, then a placement on the expiry cycle
      do_reset();
      repeat (15) step();
      chk("to_time0",  32'(time_left), 32'd0);
      chk("to_before", 32'(timeout), 32'd0);
      step();
      chk("to_pulse",  32'(timeout), 32'd1);
      chk("to_jug",    32'(jugador), 32'd0);
      chk("to_reload", 32'(time_left), 32'd15);
      step();
      chk("to_clear",  32'(timeout), 32'd0);
      chk("to_time14", 32'(time_left), 32'd14);
      repeat (14) step();
      chk("to_time0b", 32'(time_left), 32'd0);
      pulse_colocar();
      chk("to_place_no_to", 32'(timeout), 32'd0);
      chk("to_place_board", 32'(board), 32'h2);
      step();
      chk("to_place_jug",  32'(jugador), 32'd1);
      chk("to_place_time", 32'(time_left), 32'd15);

      // Full board with no line
      do_reset();
      place_at(0); place_at(1); place_at(2);
      place_at(4); place_at(3); place_at(5);
      place_at(7); place_at(6); place_at(8);
      chk("dr_board",       32'(board), 32'h16A59);
      chk("dr_board_model", 32'(board), 32'(exp_board));
      chk("dr_draw",        32'(draw), 32'd1);
      chk("dr_win",         32'(win), 32'd0);
      pulse_colocar();
      chk("dr_restart_board", 32'(board), 32'd0);
      chk("dr_restart_jug",   32'(jugador), 32'd1);
      chk("dr_restart_draw",  32'(draw), 32'd0);
      chk("dr_restart_pos",   32'(pos), 32'd8);
      pulse_mover();
      chk("dr_play_again", 32'(pos), 32'd0);

      // Reset during the check cycle of a winning move
      do_reset();
      place_at(0); place_at(3); place_at(1); place_at(4);
      move_to(2);
      pulse_colocar();
      rst = 1'b0;
      #1;
      chk("mr_board", 32'(board), 32'd0);
      chk("mr_pos",   32'(pos), 32'd0);
      chk("mr_jug",   32'(jugador), 32'd1);
      chk("mr_time",  32'(time_left), 32'd15);
      chk("mr_win",   32'({win, winner}), 32'd0);
      step();
      chk("mr_win_hold", 32'(win), 32'd0);
      rst = 1'b1;
      step();
      chk("mr_after", 32'({win, draw}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
